video_sig_gen: RTL and testbench

//  Video timing generator for the display path; drives hcount/vcount consumed by
//  the renderer's frame-buffer read port and the TMDS/HDMI output stage.

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/video_sig_gen_if.sv | 24 ++
 rtl/timing_axis_counter.sv | 58 +++++
 rtl/video_sig_gen.sv | 77 +++++++
 tb/tb_video_sig_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: CEA 1280x720@60 timing constants and the per-axis region encoding
package video_timing_pkg;

    localparam int CEA_H_ACTIVE = 1280;
    localparam int CEA_H_FP     = 110;
    localparam int CEA_H_SYNC   = 40;
    localparam int CEA_H_BP     = 220;
    localparam int CEA_V_ACTIVE = 720;
    localparam int CEA_V_FP     = 5;
    localparam int CEA_V_SYNC   = 5;
    localparam int CEA_V_BP     = 20;

    typedef enum logic [1:0] {
        RG_ACTIVE,
        RG_FP,
        RG_SYNC,
        RG_BP
    } region_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_sig_gen_if.sv
// video_sig_gen_if: timing outputs bundle from the generator to the renderer / TMDS stage
interface video_sig_gen_if #(
    parameter int HW  = 11,
    parameter int VW  = 10,
    parameter int FCW = 6
);

    logic [HW-1:0]  hcount_out;
    logic [VW-1:0]  vcount_out;
    logic           hs_out;
    logic           vs_out;
    logic           ad_out;
    logic           nf_out;
    logic [FCW-1:0] fc_out;

    modport master (
        output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
    );

    modport slave (
        input hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
    );

endinterface

// File: rtl/timing_axis_counter.sv
// timing_axis_counter: one timing axis (pixels or lines) with count, region FSM and wrap tick
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = CEA_H_ACTIVE,
    parameter int FP     = CEA_H_FP,
    parameter int SYNC   = CEA_H_SYNC,
    parameter int BP     = CEA_H_BP,
    parameter int W      = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_in,
    output logic [W-1:0] count_out,
    output logic [W-1:0] next_out,
    output logic         sync_out,
    output logic         wrap_out
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W-1:0] B_FP   = W'(ACTIVE);
    localparam logic [W-1:0] B_SYNC = W'(ACTIVE + FP);
    localparam logic [W-1:0] B_BP   = W'(ACTIVE + FP + SYNC);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_region
        $error("timing_axis_counter: every region needs at least one count");
    end

    region_t region;

    assign wrap_out = tick_in && count_out == LAST;
    assign next_out = !tick_in ? count_out : (count_out == LAST ? '0 : count_out + 1'b1);

    // Count and region advance together; sync flag is decoded from the next count so it lines up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out <= LAST;
            region    <= RG_BP;
            sync_out  <= 1'b0;
        end else if (tick_in) begin
            count_out <= next_out;
            case (region)
                RG_ACTIVE: if (next_out == B_FP) region <= RG_FP;
                RG_FP: if (next_out == B_SYNC) begin
                    region   <= RG_SYNC;
                    sync_out <= 1'b1;
                end
                RG_SYNC: if (next_out == B_BP) begin
                    region   <= RG_BP;
                    sync_out <= 1'b0;
                end
                default: if (next_out == '0) region <= RG_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/video_sig_gen.sv
// video_sig_gen: free-running video timing generator (counters, sync, active draw, frame pulse/counter)
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = CEA_H_ACTIVE,
    parameter int H_FP     = CEA_H_FP,
    parameter int H_SYNC   = CEA_H_SYNC,
    parameter int H_BP     = CEA_H_BP,
    parameter int V_ACTIVE = CEA_V_ACTIVE,
    parameter int V_FP     = CEA_V_FP,
    parameter int V_SYNC   = CEA_V_SYNC,
    parameter int V_BP     = CEA_V_BP,
    parameter int FC_WIDTH = 6,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic            clk_pixel_in,
    input  logic            rst_n_in,
    video_sig_gen_if.master vid
);

    localparam int HT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);

    logic [HW-1:0] h_count, h_next;
    logic [VW-1:0] v_count, v_next;
    logic          h_sync, h_wrap;
    logic          v_sync, v_wrap_unused;
    logic          nf_next;

    timing_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
    ) u_h (
        .clk       (clk_pixel_in),
        .rst_n     (rst_n_in),
        .tick_in   (1'b1),
        .count_out (h_count),
        .next_out  (h_next),
        .sync_out  (h_sync),
        .wrap_out  (h_wrap)
    );

    timing_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
    ) u_v (
        .clk       (clk_pixel_in),
        .rst_n     (rst_n_in),
        .tick_in   (h_wrap),
        .count_out (v_count),
        .next_out  (v_next),
        .sync_out  (v_sync),
        .wrap_out  (v_wrap_unused)
    );

    assign nf_next        = h_next == H_ACT && v_next == V_ACT;
    assign vid.hcount_out = h_count;
    assign vid.vcount_out = v_count;
    assign vid.hs_out     = SYNC_POL ? h_sync : !h_sync;
    assign vid.vs_out     = SYNC_POL ? v_sync : !v_sync;

    // Active-draw, new-frame pulse and frame counter, decoded from the next counts to stay aligned
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vid.ad_out <= 1'b0;
            vid.nf_out <= 1'b0;
            vid.fc_out <= '0;
        end else begin
            vid.ad_out <= h_next < H_ACT && v_next < V_ACT;
            vid.nf_out <= nf_next;
            vid.fc_out <= vid.fc_out + FC_WIDTH'(nf_next);
        end
    end

endmodule

// File: tb/tb_video_sig_gen.sv
// tb_video_sig_gen: directed checks of the 720p generator and a small-parameter instance
module tb_video_sig_gen;

    logic clk = 1'b0;
    logic rst_big_n = 1'b0;
    logic rst_sm_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    video_sig_gen_if #(.HW(11), .VW(10), .FCW(6)) big_if ();
    video_sig_gen_if #(.HW(3), .VW(3), .FCW(6)) sm_if ();

    video_sig_gen dut_big (
        .clk_pixel_in (clk),
        .rst_n_in     (rst_big_n),
        .vid          (big_if)
    );

    video_sig_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FC_WIDTH(6), .SYNC_POL(1'b0)
    ) dut_sm (
        .clk_pixel_in (clk),
        .rst_n_in     (rst_sm_n),
        .vid          (sm_if)
    );

    task automatic test_reset;
        bit ok = 0;
        @(negedge clk);
        rst_big_n = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (big_if.hcount_out == 11'd1400) ok = 1;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rst_reach_sync: got no hcount 1400 expected within 4000 cycles"); end
        vectors++;
        if (big_if.hs_out !== 1'b1) begin miscompares++; $display("FAIL rst_hs_pre: got %b expected 1", big_if.hs_out); end
        #2 rst_big_n = 1'b0;
        #1;
        vectors++;
        if (big_if.hcount_out !== 11'd1649) begin miscompares++; $display("FAIL rst_hcount: got %0d expected 1649", big_if.hcount_out); end
        vectors++;
        if (big_if.vcount_out !== 10'd749) begin miscompares++; $display("FAIL rst_vcount: got %0d expected 749", big_if.vcount_out); end
        vectors++;
        if (big_if.hs_out !== 1'b0 || big_if.vs_out !== 1'b0) begin miscompares++; $display("FAIL rst_sync: got hs=%b vs=%b expected 0 0", big_if.hs_out, big_if.vs_out); end
        vectors++;
        if (big_if.ad_out !== 1'b0 || big_if.nf_out !== 1'b0) begin miscompares++; $display("FAIL rst_ad_nf: got ad=%b nf=%b expected 0 0", big_if.ad_out, big_if.nf_out); end
        vectors++;
        if (big_if.fc_out !== 6'd0) begin miscompares++; $display("FAIL rst_fc: got %0d expected 0", big_if.fc_out); end
        @(negedge clk);
        rst_big_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (big_if.hcount_out !== 11'd0 || big_if.vcount_out !== 10'd0) begin miscompares++; $display("FAIL rst_first_pos: got (%0d,%0d) expected (0,0)", big_if.hcount_out, big_if.vcount_out); end
        vectors++;
        if (big_if.ad_out !== 1'b1) begin miscompares++; $display("FAIL rst_first_ad: got %b expected 1", big_if.ad_out); end
    endtask

    task automatic test_line;
        int hs_hi = 0;
        int ad_hi = 0;
        int last_rise = -1;
        int rises = 0;
        int bad_ad = 0;
        logic prev = big_if.hs_out;
        for (int i = 0; i < 3 * 1650; i++) begin
            @(negedge clk);
            if (big_if.vcount_out == 10'd0) begin
                hs_hi += int'(big_if.hs_out);
                ad_hi += int'(big_if.ad_out);
            end
            if (big_if.ad_out && big_if.hcount_out >= 11'd1280) bad_ad++;
            if (big_if.hs_out && !prev) begin
                vectors++;
                if (big_if.hcount_out !== 11'd1390) begin miscompares++; $display("FAIL line_hs_start: got %0d expected 1390", big_if.hcount_out); end
                if (last_rise >= 0) begin
                    vectors++;
                    if (i - last_rise != 1650) begin miscompares++; $display("FAIL line_hs_period: got %0d expected 1650", i - last_rise); end
                end
                last_rise = i;
                rises++;
            end
            prev = big_if.hs_out;
        end
        vectors++;
        if (hs_hi != 40) begin miscompares++; $display("FAIL line_hs_width: got %0d expected 40", hs_hi); end
        vectors++;
        if (ad_hi != 1280) begin miscompares++; $display("FAIL line_ad_width: got %0d expected 1280", ad_hi); end
        vectors++;
        if (rises != 3) begin miscompares++; $display("FAIL line_hs_rises: got %0d expected 3", rises); end
        vectors++;
        if (bad_ad != 0) begin miscompares++; $display("FAIL line_ad_blank: got %0d expected 0", bad_ad); end
    endtask

    task automatic test_small_model;
        int mh = 7;
        int mv = 5;
        int mfc = 0;
        bit e_nf, e_hs, e_vs, e_ad;
        @(negedge clk);
        rst_sm_n = 1'b0;
        #1;
        vectors++;
        if (sm_if.hcount_out !== 3'd7 || sm_if.vcount_out !== 3'd5 || sm_if.hs_out !== 1'b1 || sm_if.vs_out !== 1'b1 || sm_if.ad_out !== 1'b0 || sm_if.nf_out !== 1'b0 || sm_if.fc_out !== 6'd0) begin
            miscompares++;
            $display("FAIL sm_reset: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d expected 7 5 1 1 0 0 0",
                     sm_if.hcount_out, sm_if.vcount_out, sm_if.hs_out, sm_if.vs_out, sm_if.ad_out, sm_if.nf_out, sm_if.fc_out);
        end
        @(negedge clk);
        rst_sm_n = 1'b1;
        for (int c = 0; c < 144; c++) begin
            @(posedge clk);
            mh = (mh == 7) ? 0 : mh + 1;
            if (mh == 0) mv = (mv == 5) ? 0 : mv + 1;
            e_nf = (mh == 4 && mv == 3);
            if (e_nf) mfc = (mfc + 1) % 64;
            e_hs = (mh >= 5 && mh < 7) ? 1'b0 : 1'b1;
            e_vs = (mv == 4) ? 1'b0 : 1'b1;
            e_ad = (mh < 4 && mv < 3);
            @(negedge clk);
            vectors++;
            if (sm_if.hcount_out !== 3'(mh)) begin miscompares++; $display("FAIL sm_hcount c%0d: got %0d expected %0d", c, sm_if.hcount_out, mh); end
            vectors++;
            if (sm_if.vcount_out !== 3'(mv)) begin miscompares++; $display("FAIL sm_vcount c%0d: got %0d expected %0d", c, sm_if.vcount_out, mv); end
            vectors++;
            if (sm_if.hs_out !== e_hs) begin miscompares++; $display("FAIL sm_hs c%0d: got %b expected %b", c, sm_if.hs_out, e_hs); end
            vectors++;
            if (sm_if.vs_out !== e_vs) begin miscompares++; $display("FAIL sm_vs c%0d: got %b expected %b", c, sm_if.vs_out, e_vs); end
            vectors++;
            if (sm_if.ad_out !== e_ad) begin miscompares++; $display("FAIL sm_ad c%0d: got %b expected %b", c, sm_if.ad_out, e_ad); end
            vectors++;
            if (sm_if.nf_out !== e_nf) begin miscompares++; $display("FAIL sm_nf c%0d: got %b expected %b", c, sm_if.nf_out, e_nf); end
            vectors++;
            if (sm_if.fc_out !== 6'(mfc)) begin miscompares++; $display("FAIL sm_fc c%0d: got %0d expected %0d", c, sm_if.fc_out, mfc); end
        end
    endtask

    task automatic test_frame;
        int nfs = 0;
        int last_nf = -1;
        int bad_ad = 0;
        logic prev_vs = sm_if.vs_out;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (sm_if.nf_out) begin
                vectors++;
                if (sm_if.hcount_out !== 3'd4 || sm_if.vcount_out !== 3'd3) begin miscompares++; $display("FAIL frame_nf_pos: got (%0d,%0d) expected (4,3)", sm_if.hcount_out, sm_if.vcount_out); end
                if (last_nf >= 0) begin
                    vectors++;
                    if (i - last_nf != 48) begin miscompares++; $display("FAIL frame_nf_period: got %0d expected 48", i - last_nf); end
                end
                last_nf = i;
                nfs++;
            end
            if (!sm_if.vs_out && prev_vs) begin
                vectors++;
                if (sm_if.hcount_out !== 3'd0 || sm_if.vcount_out !== 3'd4) begin miscompares++; $display("FAIL frame_vs_assert: got (%0d,%0d) expected (0,4)", sm_if.hcount_out, sm_if.vcount_out); end
            end
            if (sm_if.vs_out && !prev_vs) begin
                vectors++;
                if (sm_if.hcount_out !== 3'd0 || sm_if.vcount_out !== 3'd5) begin miscompares++; $display("FAIL frame_vs_release: got (%0d,%0d) expected (0,5)", sm_if.hcount_out, sm_if.vcount_out); end
            end
            if (sm_if.ad_out && sm_if.vcount_out >= 3'd3) bad_ad++;
            prev_vs = sm_if.vs_out;
        end
        vectors++;
        if (nfs != 2) begin miscompares++; $display("FAIL frame_nf_count: got %0d expected 2", nfs); end
        vectors++;
        if (bad_ad != 0) begin miscompares++; $display("FAIL frame_ad_vblank: got %0d expected 0", bad_ad); end
    endtask

    task automatic test_frame_counter;
        int e = 0;
        int nfs = 0;
        int glitch = 0;
        logic [5:0] prev_fc;
        @(negedge clk);
        rst_sm_n = 1'b0;
        @(negedge clk);
        rst_sm_n = 1'b1;
        prev_fc = sm_if.fc_out;
        for (int i = 0; i < 70 * 48 && nfs < 64; i++) begin
            @(negedge clk);
            if (sm_if.nf_out) begin
                e = (e + 1) % 64;
                nfs++;
                vectors++;
                if (sm_if.fc_out !== 6'(e)) begin miscompares++; $display("FAIL fc_step %0d: got %0d expected %0d", nfs, sm_if.fc_out, e); end
            end else if (sm_if.fc_out !== prev_fc) begin
                glitch++;
            end
            prev_fc = sm_if.fc_out;
        end
        vectors++;
        if (nfs != 64) begin miscompares++; $display("FAIL fc_frames: got %0d expected 64", nfs); end
        vectors++;
        if (sm_if.fc_out !== 6'd0) begin miscompares++; $display("FAIL fc_wrap: got %0d expected 0", sm_if.fc_out); end
        vectors++;
        if (glitch != 0) begin miscompares++; $display("FAIL fc_no_pulse_change: got %0d expected 0", glitch); end
    endtask

    task automatic test_reset_pulse;
        bit ok = 0;
        int bad = 0;
        @(negedge clk);
        rst_sm_n = 1'b0;
        @(negedge clk);
        rst_sm_n = 1'b1;
        for (int i = 0; i < 96 && !ok; i++) begin
            @(negedge clk);
            if (sm_if.hcount_out == 3'd3 && sm_if.vcount_out == 3'd2) ok = 1;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL pulse_reach: got no (3,2) expected within 96 cycles"); end
        rst_sm_n = 1'b0;
        #1;
        vectors++;
        if (sm_if.hcount_out !== 3'd7 || sm_if.vcount_out !== 3'd5 || sm_if.ad_out !== 1'b0 || sm_if.hs_out !== 1'b1 || sm_if.vs_out !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse_reset_vals: got h=%0d v=%0d ad=%b hs=%b vs=%b expected 7 5 0 1 1", sm_if.hcount_out, sm_if.vcount_out, sm_if.ad_out, sm_if.hs_out, sm_if.vs_out);
        end
        @(negedge clk);
        vectors++;
        if (sm_if.nf_out !== 1'b0 || sm_if.fc_out !== 6'd0) begin miscompares++; $display("FAIL pulse_no_nf: got nf=%b fc=%0d expected 0 0", sm_if.nf_out, sm_if.fc_out); end
        rst_sm_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (sm_if.hcount_out !== 3'd0 || sm_if.vcount_out !== 3'd0 || sm_if.ad_out !== 1'b1) begin miscompares++; $display("FAIL pulse_restart: got (%0d,%0d) ad=%b expected (0,0) ad=1", sm_if.hcount_out, sm_if.vcount_out, sm_if.ad_out); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sm_if.nf_out || sm_if.fc_out != 6'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL pulse_fc_hold: got %0d expected 0", bad); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line();
        test_small_model();
        test_frame();
        test_frame_counter();
        test_reset_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
